alb_mul_ctrl: RTL and testbench

Sequential 10x10 multiplier controller built around the shared `alb` adder/subtractor. It accepts two 10-bit operands, then drives `alb` once per cycle for 10 cycles using shift-and-add (unsigned) or radix-2 Booth (signed). It produces a 20-bit product. It is the first sequencing block on top of the ALB datapath and owns the only `alb` instance it uses.

---
 rtl/alb_mul_ctrl.sv | 156 +++++++++++++++
 tb/tb_alb_mul_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/alb_mul_ctrl.sv
// 10x10 sequential multiplier: shift-and-add (unsigned) or radix-2 Booth
// (signed), one alb add/subtract step per cycle, 20-bit registered product.

module alb (
    input  logic [9:0] A,
    input  logic [9:0] B,
    input  logic       CI,
    input  logic [2:0] ALB_MI,
    output logic [9:0] F,
    output logic       CO,
    output logic       VO,
    output logic       ZO,
    output logic       NO
);
    logic        w_sub;
    logic [9:0]  w_bx;
    logic        w_cx;
    logic [10:0] w_sum;

    always_comb begin
        w_sub = (ALB_MI == 3'b001);
        // subtract is A + ~B + ~CI, so CI acts as a borrow-in
        w_bx  = w_sub ? ~B : B;
        w_cx  = w_sub ? ~CI : CI;
        w_sum = {1'b0, A} + {1'b0, w_bx} + {10'd0, w_cx};
        F     = w_sum[9:0];
        CO    = w_sum[10];
        VO    = (A[9] == w_bx[9]) && (w_sum[9] != A[9]);
        case (ALB_MI)
            3'b010: begin F = A & B; CO = 1'b0; VO = 1'b0; end
            3'b011: begin F = A | B; CO = 1'b0; VO = 1'b0; end
            3'b100: begin F = A ^ B; CO = 1'b0; VO = 1'b0; end
            3'b000, 3'b001: ;
            default: begin F = A; CO = 1'b0; VO = 1'b0; end
        endcase
        ZO = (F == 10'd0);
        NO = F[9];
    end
endmodule

module alb_mul_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sgn,
    input  logic [9:0]  a,
    input  logic [9:0]  b,
    output logic        busy,
    output logic        done,
    output logic [19:0] p
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [9:0]  r_m;
    logic [9:0]  r_acc;
    logic [9:0]  r_mq;
    logic        r_q1;
    logic [3:0]  r_cnt;
    logic        r_mode_s;
    logic        r_busy;
    logic        r_done;
    logic [19:0] r_p;

    logic [9:0]  w_b;
    logic [2:0]  w_mi;
    logic [9:0]  w_f;
    logic        w_co;
    logic        w_vo;
    logic        w_unused_zo;
    logic        w_unused_no;
    logic        w_s;
    logic [19:0] w_next;

    alb u_alb (
        .A      (r_acc),
        .B      (w_b),
        .CI     (1'b0),
        .ALB_MI (w_mi),
        .F      (w_f),
        .CO     (w_co),
        .VO     (w_vo),
        .ZO     (w_unused_zo),
        .NO     (w_unused_no)
    );

    always_comb begin
        w_b  = 10'd0;
        w_mi = 3'b000;
        if (!r_mode_s) begin
            if (r_mq[0]) w_b = r_m;
        end else begin
            case ({r_mq[0], r_q1})
                2'b10: begin w_b = r_m; w_mi = 3'b001; end
                2'b01: w_b = r_m;
                default: ;
            endcase
        end
        // signed mode shifts in the true sign so overflowed sums stay exact
        w_s    = r_mode_s ? (w_f[9] ^ w_vo) : w_co;
        w_next = {w_s, w_f, r_mq[9:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_m      <= 10'd0;
            r_acc    <= 10'd0;
            r_mq     <= 10'd0;
            r_q1     <= 1'b0;
            r_cnt    <= 4'd0;
            r_mode_s <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_p      <= 20'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m      <= a;
                        r_mq     <= b;
                        r_acc    <= 10'd0;
                        r_q1     <= 1'b0;
                        r_cnt    <= 4'd0;
                        r_mode_s <= sgn;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_next[19:10];
                    r_mq  <= w_next[9:0];
                    r_q1  <= r_mq[0];
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd9) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_p     <= w_next;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign p    = r_p;
endmodule

// File: tb/tb_alb_mul_ctrl.sv
// Self-checking bench for alb_mul_ctrl: directed corners, start-while-busy,
// reset mid-run and randomized operands against an arithmetic reference.

module tb_alb_mul_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sgn = 1'b0;
    logic [9:0]  a = 10'd0;
    logic [9:0]  b = 10'd0;
    logic        busy;
    logic        done;
    logic [19:0] p;

    int          n_err = 0;
    int          n_checks = 0;
    logic [19:0] last_p = 20'd0;

    alb_mul_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sgn   (sgn),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] ref_mul(logic [9:0] x, logic [9:0] y,
                                            logic s);
        int r;
        if (s) r = int'($signed(x)) * int'($signed(y));
        else   r = int'(x) * int'(y);
        return r[19:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [19:0] obs,
                       input logic [19:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // noise[i] raises start with junk operands before the i-th edge after acceptance
    task automatic mul(input logic [9:0] ia, input logic [9:0] ib,
                       input logic isg, input logic [11:0] noise);
        logic [19:0] exp;
        exp   = ref_mul(ia, ib, isg);
        a     = ia;
        b     = ib;
        sgn   = isg;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("accept_busy", {19'd0, busy}, 20'd1);
        chk("accept_done", {19'd0, done}, 20'd0);
        for (int i = 1; i <= 11; i++) begin
            if (noise[i]) begin
                start = 1'b1;
                a     = 10'($urandom);
                b     = 10'($urandom);
                sgn   = 1'($urandom);
            end
            tick();
            start = 1'b0;
            if (i <= 9) begin
                chk("run_busy", {19'd0, busy}, 20'd1);
                chk("run_done", {19'd0, done}, 20'd0);
                chk("run_p_hold", p, last_p);
            end else if (i == 10) begin
                chk("fin_busy", {19'd0, busy}, 20'd0);
                chk("fin_done", {19'd0, done}, 20'd1);
                chk("fin_p", p, exp);
            end else begin
                chk("idle_busy", {19'd0, busy}, 20'd0);
                chk("idle_done", {19'd0, done}, 20'd0);
                chk("idle_p", p, exp);
            end
        end
        last_p = exp;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        tick();
        tick();
        chk("rst_busy", {19'd0, busy}, 20'd0);
        chk("rst_done", {19'd0, done}, 20'd0);
        chk("rst_p", p, 20'd0);
        start = 1'b0;
        rst   = 1'b0;
        tick();
        chk("idle_p0", p, 20'd0);

        mul(10'h18E, 10'h297, 1'b0, 12'd0);
        chk("ex_unsigned", p, 20'h406C2);
        mul(10'h18E, 10'h297, 1'b1, 12'd0);
        chk("ex_signed", p, 20'hDCEC2);
        mul(10'h3FF, 10'h3FF, 1'b0, 12'd0);
        chk("u_max", p, 20'hFF801);
        mul(10'h3FF, 10'h3FF, 1'b1, 12'd0);
        chk("s_m1sq", p, 20'h00001);
        mul(10'h200, 10'h200, 1'b1, 12'd0);
        chk("s_minsq", p, 20'h40000);
        mul(10'd3, 10'h3FB, 1'b1, 12'd0);
        chk("s_3xm5", p, 20'hFFFF1);

        // start pulses at cycles 3, 10 and during DONE must be ignored
        mul(10'h155, 10'h0AA, 1'b0, 12'b1100_0000_1000);
        chk("noise_p", p, ref_mul(10'h155, 10'h0AA, 1'b0));

        a     = 10'h2A5;
        b     = 10'h13C;
        sgn   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", {19'd0, busy}, 20'd0);
        chk("mid_rst_done", {19'd0, done}, 20'd0);
        chk("mid_rst_p", p, 20'd0);
        last_p = 20'd0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("post_rst_nodone", {19'd0, done}, 20'd0);
        end
        mul(10'd7, 10'd9, 1'b0, 12'd0);
        chk("post_rst_7x9", p, 20'd63);

        for (int n = 0; n < 24; n++) begin
            mul(10'($urandom), 10'($urandom), 1'($urandom),
                12'($urandom) & 12'hFFE);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
